// File: rtl/reg_bank_loader.sv
// Frame-based loader: collects a header plus up to three data beats into shadow registers,
// then commits them to the register bank as one-hot CE strobes, one register per cycle.
module reg_bank_loader #(
    parameter int DW  = 8,
    parameter int TMO = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] S_DATA,
    input  logic          S_VALID,
    output logic          S_READY,
    input  logic          ABORT,
    output logic [DW-1:0] DIN,
    output logic          RG1,
    output logic          RG2,
    output logic          RG3,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR,
    output logic [1:0]    dbg_state
);
    // Stream handshake: a beat transfers on a rising CLK edge where S_VALID and S_READY
    // are both 1; the source holds S_DATA/S_VALID stable until that edge.

    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t        state;
    logic [2:0]    mask;
    logic [2:0]    pend;
    logic [2:0]    cpend;
    logic [2:0]    rg;
    logic [CW-1:0] idle_cnt;
    logic [DW-1:0] shadow   [3];
    logic [DW-1:0] shadow_m [3];

    logic          beat;
    logic          hdr_ok;
    logic [2:0]    pend_low;
    logic          last_beat;
    logic [2:0]    src;
    logic [2:0]    strobe;
    logic [DW-1:0] strobe_din;

    assign beat      = S_VALID & S_READY;
    assign hdr_ok    = (S_DATA[DW-1:3] == '0) && (S_DATA[2:0] != 3'd0);
    assign pend_low  = pend & (~pend + 3'd1);
    assign last_beat = (pend == pend_low);
    assign RG1       = rg[0];
    assign RG2       = rg[1];
    assign RG3       = rg[2];
    assign dbg_state = state;

    // The first strobe is launched on the edge that accepts the last beat, so the
    // shadow view must already include that beat.
    always_comb begin
        shadow_m = shadow;
        if (beat && state == COLLECT) begin
            for (int i = 0; i < 3; i++) begin
                if (pend_low[i]) shadow_m[i] = S_DATA;
            end
        end
        src    = (state == COMMIT) ? cpend : mask;
        strobe = src & (~src + 3'd1);
        strobe_din = '0;
        for (int i = 0; i < 3; i++) begin
            if (strobe[i]) strobe_din = shadow_m[i];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            S_READY  <= 1'b0;
            DIN      <= '0;
            rg       <= 3'd0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            mask     <= 3'd0;
            pend     <= 3'd0;
            cpend    <= 3'd0;
            idle_cnt <= '0;
            for (int i = 0; i < 3; i++) shadow[i] <= '0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            rg   <= 3'd0;
            DIN  <= '0;
            case (state)
                IDLE: begin
                    S_READY <= 1'b1;
                    BUSY    <= 1'b0;
                    if (beat) begin
                        if (hdr_ok) begin
                            mask     <= S_DATA[2:0];
                            pend     <= S_DATA[2:0];
                            idle_cnt <= '0;
                            BUSY     <= 1'b1;
                            state    <= COLLECT;
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (ABORT) begin
                        ERR   <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else if (beat) begin
                        shadow   <= shadow_m;
                        idle_cnt <= '0;
                        pend     <= pend & ~pend_low;
                        if (last_beat) begin
                            state   <= COMMIT;
                            S_READY <= 1'b0;
                            rg      <= strobe;
                            DIN     <= strobe_din;
                            cpend   <= mask & ~strobe;
                            DONE    <= ((mask & ~strobe) == 3'd0);
                        end
                    end else if (idle_cnt == CW'(TMO - 1)) begin
                        ERR   <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end
                COMMIT: begin
                    if (cpend != 3'd0) begin
                        rg    <= strobe;
                        DIN   <= strobe_din;
                        cpend <= cpend & ~strobe;
                        DONE  <= ((cpend & ~strobe) == 3'd0);
                    end else begin
                        state   <= IDLE;
                        BUSY    <= 1'b0;
                        S_READY <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_bank_loader.sv
// Bench for reg_bank_loader: frame-level reference model compared every cycle, directed
// frames with literal strobe logs, then randomized frames with gaps, timeouts and aborts.
module tb_reg_bank_loader;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          abort;
    logic [DW-1:0] din;
    logic          rg1, rg2, rg3;
    logic          busy, done, err;
    logic [1:0]    dbg_state;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;

    logic [11:0] log_q[$];
    logic [11:0] exp_q[$];

    reg_bank_loader #(.DW(DW), .TMO(TMO)) dut (
        .CLK(clk), .RST(rst_n), .S_DATA(s_data), .S_VALID(s_valid), .S_READY(s_ready),
        .ABORT(abort), .DIN(din), .RG1(rg1), .RG2(rg2), .RG3(rg3), .BUSY(busy),
        .DONE(done), .ERR(err), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: expected outputs for the current cycle
    int          phase;
    logic        e_ready, e_busy, e_done, e_err;
    logic [2:0]  e_rg;
    logic [7:0]  e_din;
    logic [2:0]  m_mask;
    int          m_idle;
    logic [7:0]  m_data[$];
    logic [10:0] m_cq[$];
    logic [10:0] m_ent;
    logic        m_beat;
    int          m_j;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase = 0; e_ready = 0; e_busy = 0; e_done = 0; e_err = 0; e_rg = 0; e_din = 0;
            m_idle = 0; m_mask = 0;
            m_data.delete();
            m_cq.delete();
        end else begin
            m_beat = s_valid && e_ready;
            e_done = 0; e_err = 0; e_rg = 0; e_din = 0;
            case (phase)
                0: begin
                    e_ready = 1;
                    if (m_beat) begin
                        if (s_data[7:3] != 0 || s_data[2:0] == 0) begin
                            e_err = 1;
                        end else begin
                            m_mask = s_data[2:0];
                            m_data.delete();
                            m_idle = 0;
                            phase = 1;
                            e_busy = 1;
                        end
                    end
                end
                1: begin
                    if (abort) begin
                        e_err = 1; phase = 0; e_busy = 0;
                    end else if (m_beat) begin
                        m_data.push_back(s_data);
                        m_idle = 0;
                        if (m_data.size() == $countones(m_mask)) begin
                            m_j = 0;
                            for (int i = 0; i < 3; i++) begin
                                if (m_mask[i]) begin
                                    m_cq.push_back({3'(1 << i), m_data[m_j]});
                                    m_j++;
                                end
                            end
                            phase = 2;
                            e_ready = 0;
                            m_ent = m_cq.pop_front();
                            e_rg = m_ent[10:8]; e_din = m_ent[7:0];
                            e_done = (m_cq.size() == 0);
                        end
                    end else begin
                        m_idle++;
                        if (m_idle == TMO) begin
                            e_err = 1; phase = 0; e_busy = 0;
                        end
                    end
                end
                default: begin
                    if (m_cq.size() > 0) begin
                        m_ent = m_cq.pop_front();
                        e_rg = m_ent[10:8]; e_din = m_ent[7:0];
                        e_done = (m_cq.size() == 0);
                    end else begin
                        phase = 0; e_busy = 0; e_ready = 1;
                    end
                end
            endcase
        end
    end

    // scoreboard: every cycle, plus strobe log and ERR count for directed checks
    logic [14:0] act_v, exp_v;
    always @(negedge clk) begin
        act_v = {s_ready, busy, done, err, rg3, rg2, rg1, din};
        exp_v = {e_ready, e_busy, e_done, e_err, e_rg, e_din};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL outputs t=%0t actual rdy/busy/done/err/rg/din=%b_%b_%b_%b_%b_%h required=%b_%b_%b_%b_%b_%h",
                     $time, act_v[14], act_v[13], act_v[12], act_v[11], act_v[10:8], act_v[7:0],
                     exp_v[14], exp_v[13], exp_v[12], exp_v[11], exp_v[10:8], exp_v[7:0]);
        end
        if (rst_n && (rg1 | rg2 | rg3)) log_q.push_back({rg3, rg2, rg1, din, done});
        if (rst_n && err) err_cnt++;
    end

    task automatic check_val(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic check_log(input string name);
        checks++;
        if (log_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s strobe count actual=%0d required=%0d", name, log_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                if (log_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL %s strobe %0d actual rg/din/done=%h required=%h", name, i, log_q[i], exp_q[i]);
                    break;
                end
            end
        end
        log_q.delete();
        exp_q.delete();
    endtask

    // driver tasks: called at posedge+1, return at posedge+1
    task automatic send_beat(input logic [7:0] d, input logic ab);
        int  n;
        logic acc;
        s_valid = 1; s_data = d; abort = ab;
        n = 0; acc = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (s_ready) acc = 1;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            failures++;
            $display("FAIL beat_timeout actual=not_accepted required=accepted data=%h", d);
        end
        s_valid = 0; abort = 0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_rand(input int n);
        repeat (n) begin
            abort = ($urandom_range(0, 29) == 0);
            @(posedge clk);
            #1;
        end
        abort = 0;
    endtask

    int e0;
    logic [7:0] hdr;

    initial begin
        rst_n = 0; s_valid = 0; s_data = 0; abort = 0;
        #2;
        checks++;
        if ({s_ready, busy, done, err, rg1, rg2, rg3, din} !== '0) begin
            failures++;
            $display("FAIL reset_state actual=%b required=0", {s_ready, busy, done, err, rg1, rg2, rg3, din});
        end
        idle_cycles(3);
        rst_n = 1;
        idle_cycles(2);
        log_q.delete();
        err_cnt = 0;

        // 1: full frame
        send_beat(8'h07, 0); send_beat(8'hA5, 0); send_beat(8'h3C, 0); send_beat(8'h09, 0);
        idle_cycles(6);
        exp_q = '{{3'b001, 8'hA5, 1'b0}, {3'b010, 8'h3C, 1'b0}, {3'b100, 8'h09, 1'b1}};
        check_log("frame_07");
        check_val("frame_07_err", err_cnt, 0);

        // 2: sparse mask
        send_beat(8'h05, 0); send_beat(8'h11, 0); send_beat(8'h22, 0);
        idle_cycles(5);
        exp_q = '{{3'b001, 8'h11, 1'b0}, {3'b100, 8'h22, 1'b1}};
        check_log("frame_05");

        // 3: rejected headers
        e0 = err_cnt;
        send_beat(8'h00, 0); send_beat(8'h09, 0);
        idle_cycles(3);
        check_val("bad_hdr_err", err_cnt - e0, 2);
        check_log("bad_hdr_no_strobe");

        // 4: timeout then fresh frame
        e0 = err_cnt;
        send_beat(8'h07, 0); send_beat(8'h44, 0);
        idle_cycles(TMO + 4);
        check_val("timeout_err", err_cnt - e0, 1);
        check_log("timeout_no_strobe");
        send_beat(8'h01, 0); send_beat(8'h5A, 0);
        idle_cycles(4);
        exp_q = '{{3'b001, 8'h5A, 1'b1}};
        check_log("after_timeout");

        // 5: abort wins over beat; reset during commit
        e0 = err_cnt;
        send_beat(8'h03, 0); send_beat(8'h12, 0); send_beat(8'h34, 1);
        idle_cycles(4);
        check_val("abort_err", err_cnt - e0, 1);
        check_log("abort_no_strobe");
        send_beat(8'h07, 0); send_beat(8'hA1, 0); send_beat(8'hB2, 0); send_beat(8'hC3, 0);
        @(negedge clk);
        @(posedge clk);
        #2;
        check_val("rg2_before_rst", int'(rg2), 1);
        rst_n = 0;
        #1;
        check_val("rst_async_outputs", int'({s_ready, busy, done, err, rg1, rg2, rg3, din}), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        idle_cycles(5);
        exp_q = '{{3'b001, 8'hA1, 1'b0}};
        check_log("rst_mid_commit");

        // 6: valid held through COMMIT becomes next header
        send_beat(8'h01, 0); send_beat(8'h77, 0);
        send_beat(8'h02, 0); send_beat(8'h33, 0);
        idle_cycles(4);
        exp_q = '{{3'b001, 8'h77, 1'b1}, {3'b010, 8'h33, 1'b1}};
        check_log("held_valid_b2b");

        // randomized frames
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 7) == 0) hdr = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(8, 255));
            else hdr = 8'($urandom_range(1, 7));
            send_beat(hdr, 0);
            if (hdr[7:3] == 0 && hdr[2:0] != 0) begin
                for (int b = 0; b < $countones(hdr[2:0]); b++) begin
                    if ($urandom_range(0, 19) == 0) idle_rand($urandom_range(TMO - 2, TMO + 2));
                    else idle_rand($urandom_range(0, 3));
                    send_beat(8'($urandom), $urandom_range(0, 24) == 0);
                end
            end
            idle_rand($urandom_range(0, 2));
        end
        idle_cycles(TMO + 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
